// File: rtl/ram_sp_pkg.sv
// ram_sp_pkg: shared widths and response-buffer depth limits for the block-RAM initiator.
package ram_sp_pkg;
    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 16;
    localparam int RSP_DEPTH_MIN = 2;
    localparam int RSP_DEPTH_MAX = 8;
endpackage

// File: rtl/ram_sp_rsp_fifo.sv
// ram_sp_rsp_fifo: DEPTH x DATA_W circular response FIFO, pointers wrap modulo DEPTH.
// Ports: clk, rst_n (async, active-low); push/din write; pop reads the head;
//        dout is the head entry (0 when empty); occ is the entry count; empty flag.
module ram_sp_rsp_fifo import ram_sp_pkg::*; #(
    parameter int DEPTH  = RSP_DEPTH_MIN,
    parameter int DATA_W = DATA_W_DEF,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [OW-1:0]     occ,
    output logic              empty
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [OW-1:0]     occ_q, occ_d;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_d  = push ? inc(wr_q) : wr_q;
        rd_d  = pop ? inc(rd_q) : rd_q;
        occ_d = occ_q + OW'(push) - OW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    // Stale entries are masked so the response data reads 0 whenever nothing is buffered.
    assign empty = (occ_q == '0);
    assign dout  = empty ? '0 : mem_q[rd_q];
    assign occ   = occ_q;
endmodule

// File: rtl/ram_sp_initiator.sv
// ram_sp_initiator: requester side of a single-port write-first block-RAM port.
// Ports: clk, rst_n (async, active-low); req_* valid/ready request channel;
//        rsp_* valid/ready in-order response channel; ram_* drive of the RAM port,
//        ram_dout is the RAM registered output (valid the cycle after ram_en).
// Macro RAM_SP_INIT_WR_RSP_EN: when defined, writes return their write-first echo
//        as a response and consume a credit; otherwise writes complete at issue.
module ram_sp_initiator import ram_sp_pkg::*; #(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam int DEPTH = (RSP_DEPTH < RSP_DEPTH_MIN) ? RSP_DEPTH_MIN :
                           (RSP_DEPTH > RSP_DEPTH_MAX) ? RSP_DEPTH_MAX : RSP_DEPTH;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          inflt_q, inflt_d;
    logic          live_q;
    logic          pop, empty, rsp_gen;
    logic [OW-1:0] occ;
    logic [OW:0]   credits;

`ifdef RAM_SP_INIT_WR_RSP_EN
    assign rsp_gen = 1'b1;
`else
    assign rsp_gen = ~req_we;
`endif

    // Buffer slots already spoken for: stored entries plus the one landing this
    // cycle, minus the one leaving, so a pop frees a slot in the same cycle.
    always_comb begin
        pop       = rsp_valid & rsp_ready;
        credits   = {1'b0, occ} + (OW+1)'(inflt_q) - (OW+1)'(pop);
        req_ready = live_q & (credits < (OW+1)'(DEPTH));
        ram_en    = req_valid & req_ready;
        ram_we    = req_we;
        ram_addr  = req_addr;
        ram_di    = req_wdata;
        inflt_d   = ram_en & rsp_gen;
    end

    // live_q keeps req_ready low while reset is held without feeding rst_n into data paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflt_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            inflt_q <= inflt_d;
            live_q  <= 1'b1;
        end
    end

    ram_sp_rsp_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflt_q),
        .din   (ram_dout),
        .pop   (pop),
        .dout  (rsp_rdata),
        .occ   (occ),
        .empty (empty)
    );

    assign rsp_valid = ~empty;
endmodule

// File: tb/tb_ram_sp_initiator.sv
// tb_ram_sp_initiator: directed, table-driven bench for ram_sp_initiator with a 16x16 RAM model.
module tb_ram_sp_initiator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, ram_en, ram_we;
    logic [15:0] rsp_rdata, ram_addr, ram_di;
    logic [15:0] ram_dout = '0;
    logic [15:0] ram_mem [16];

    int total = 0, bad = 0, nacc = 0, nrsp = 0;
    logic [15:0] shadow [16];
    logic [15:0] expq [$];
    logic        hold_pend = 1'b0;
    logic [15:0] hold_val = '0;

    typedef struct {
        logic v, we; logic [15:0] a, d; logic rr;
        logic x_rdy, x_en, x_rv; logic [15:0] x_rd;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    ram_sp_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_dout(ram_dout)
    );

    // Write-first single-port RAM with registered output.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr[3:0]] <= ram_di;
                ram_dout <= ram_di;
            end else begin
                ram_dout <= ram_mem[ram_addr[3:0]];
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, score responses against expq.
    task automatic cyc(input logic v, input logic we, input logic [15:0] a, input logic [15:0] d, input logic rr);
        @(negedge clk);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
        #1;
        if (hold_pend) begin
            chk("rsp_hold_valid", rsp_valid, 1);
            chk("rsp_hold_data", rsp_rdata, hold_val);
        end
        hold_pend = 1'b0;
        if (rsp_valid && rr) begin
            nrsp++;
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got %h want none", rsp_rdata);
            end else begin
                logic [15:0] e;
                e = expq.pop_front();
                if (rsp_rdata !== e) begin
                    bad++;
                    $display("FAIL rsp_data: got %h want %h", rsp_rdata, e);
                end
            end
        end
        if (rsp_valid && !rr) begin
            hold_pend = 1'b1;
            hold_val = rsp_rdata;
        end
        if (v && req_ready) begin
            nacc++;
            if (we) begin
                shadow[a[3:0]] = d;
`ifdef RAM_SP_INIT_WR_RSP_EN
                expq.push_back(d);
`endif
            end else begin
                expq.push_back(shadow[a[3:0]]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int base, r0;
        for (int i = 0; i < 16; i++) begin ram_mem[i] = '0; shadow[i] = '0; end
        tbl[0] = '{1, 1, 16'h0005, 16'h1234, 1, 1, 1, 0, 16'h0000};
        tbl[1] = '{1, 0, 16'h0005, 16'h0000, 1, 1, 1, 0, 16'h0000};
        tbl[2] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000};
        tbl[3] = '{0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 16'h1234};
        tbl[4] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h1234};
        tbl[5] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000};

        // Reset: requester is pushing but nothing may be accepted or issued.
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        req_valid = 1'b0;
        rst_n = 1'b1;

`ifndef RAM_SP_INIT_WR_RSP_EN
        // Test 1: write 0x1234 @5 then read @5, no write response.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = tbl[i].v; req_we = tbl[i].we; req_addr = tbl[i].a;
            req_wdata = tbl[i].d; rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("t1_ready[%0d]", i), req_ready, tbl[i].x_rdy);
            chk($sformatf("t1_ram_en[%0d]", i), ram_en, tbl[i].x_en);
            chk($sformatf("t1_rsp_valid[%0d]", i), rsp_valid, tbl[i].x_rv);
            chk($sformatf("t1_rsp_rdata[%0d]", i), rsp_rdata, tbl[i].x_rd);
        end
        shadow[5] = 16'h1234;
`endif

        // Test 2: fill RAM, then 16 back-to-back reads with responses on consecutive cycles.
        for (int i = 0; i < 16; i++) cyc(1, 1, 16'(i), 16'hA000 + 16'(i), 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        for (int c = 0; c < 18; c++) begin
            cyc(c < 16, 0, 16'(c), 0, 1);
            if (c < 16) chk("t2_ready", req_ready, 1);
            chk("t2_rsp_valid", rsp_valid, c >= 2);
        end
        chk("t2_all_returned", expq.size(), 0);

        // Test 3: stalled consumer, only RSP_DEPTH reads accepted.
        base = nacc;
        r0 = nrsp;
        for (int i = 0; i < 4; i++) cyc(1, 0, 16'(nacc - base + 1), 0, 0);
        chk("t3_accepted", nacc - base, 2);
        chk("t3_ready_full", req_ready, 0);
        chk("t3_en_full", ram_en, 0);
        chk("t3_rsp_valid_full", rsp_valid, 1);

        // Test 4: full buffer, pop frees a credit in the same cycle a new read issues.
        cyc(1, 0, 16'(nacc - base + 1), 0, 1);
        chk("t4_ready_pop", req_ready, 1);
        chk("t4_en_pop", ram_en, 1);
        for (int j = 0; j < 20 && (nrsp - r0) < 4; j++)
            cyc((nacc - base) < 4, 0, 16'(nacc - base + 1), 0, 1);
        chk("t3_rsp_count", nrsp - r0, 4);
        chk("t3_queue_empty", expq.size(), 0);
        cyc(0, 0, 0, 0, 1);
        chk("t3_no_extra", rsp_valid, 0);

        // Test 5: reset the cycle after a read issue discards it.
        cyc(1, 0, 16'h0003, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b1;
        #1;
        chk("t5_rst_ready", req_ready, 0);
        chk("t5_rst_en", ram_en, 0);
        chk("t5_rst_rsp_valid", rsp_valid, 0);
        chk("t5_rst_rsp_rdata", rsp_rdata, 0);
        expq.delete();
        hold_pend = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("t5_no_rsp", rsp_valid, 0);
        end
        r0 = nrsp;
        cyc(1, 0, 16'h0009, 0, 1);
        chk("t5_read_accepted", req_ready, 1);
        for (int j = 0; j < 10 && nrsp == r0; j++) cyc(0, 0, 0, 0, 1);
        chk("t5_rsp_count", nrsp - r0, 1);

        // Test 6: write echo and credit use depend on the macro.
        cyc(1, 1, 16'h0020, 16'hBEEF, 0);
        chk("t6_ram_en", ram_en, 1);
        chk("t6_ram_we", ram_we, 1);
        chk("t6_ram_addr", ram_addr, 16'h0020);
        chk("t6_ram_di", ram_di, 16'hBEEF);
        cyc(1, 0, 16'h0002, 0, 0);
        cyc(1, 1, 16'h0021, 16'h1111, 0);
`ifdef RAM_SP_INIT_WR_RSP_EN
        chk("t6_credit_ready", req_ready, 0);
        chk("t6_rsp_valid", rsp_valid, 1);
        chk("t6_rsp_data", rsp_rdata, 16'hBEEF);
`else
        chk("t6_credit_ready", req_ready, 1);
        chk("t6_rsp_valid", rsp_valid, 0);
`endif
        repeat (6) cyc(0, 0, 0, 0, 1);
        chk("t6_queue_empty", expq.size(), 0);
        chk("t6_idle", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
